// File: rtl/nios2_c_sd_pkg.sv
// Shared definitions for the SD 4-bit DAT block receiver: FSM states, register map
// and CRC polynomial.
package nios2_c_sd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_DATA,
        ST_CRC,
        ST_END,
        ST_DONE
    } state_t;

    localparam logic [1:0] ADDR_CTRL  = 2'd0;
    localparam logic [1:0] ADDR_DATA  = 2'd1;
    localparam logic [1:0] ADDR_WORDS = 2'd2;

    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CLR    = 2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_CRC_ERR = 2;
    localparam int STAT_END_ERR = 3;
    localparam int STAT_TIMEOUT = 4;
    localparam int STAT_IRQ_EN  = 5;
    localparam int STAT_MASK_LO = 8;

    localparam logic [15:0] CRC16_POLY = 16'h1021;

endpackage

// File: rtl/nios2_c_sd_crc16_line.sv
// Bit-serial CRC16-CCITT (init 0) for one DAT line.
module nios2_c_sd_crc16_line
    import nios2_c_sd_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;
    assign fb = din ^ crc[15];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/nios2_c_sd_dat_rx.sv
// SD 4-bit data block receiver with Avalon-MM slave: clock generation, start-bit
// search, nibble packing into a word FIFO, per-line CRC16 and end-bit check.
module nios2_c_sd_dat_rx
    import nios2_c_sd_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int BLOCK_BYTES = 512,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        sd_clk,
    input  logic [3:0]  sd_dat_in
);

    localparam int DEPTH   = BLOCK_BYTES / 4;
    localparam int NIBBLES = BLOCK_BYTES * 2;
    localparam int CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW      = $clog2(DEPTH + 1);
    localparam int NW      = $clog2(NIBBLES + 1);
    localparam int TW      = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [NW-1:0] NIB_LAST = NW'(NIBBLES - 1);
    localparam logic [NW-1:0] CRC_LAST = NW'(15);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    state_t          state;
    logic [CW-1:0]   div_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [NW-1:0]   nib_cnt;
    logic [2:0]      nib_idx;
    logic [4:0]      nib_off;
    logic [31:0]     word_buf;
    logic            push_pend;
    logic            done, crc_err, end_err, timeout, irq_en;
    logic [3:0]      fail_mask;
    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;
    logic [15:0]     crc_line [4];
    logic [3:0]      crc_miss;
    logic            running, rise_en, ctrl_wr, start_ok, pop, crc_en;
    logic [31:0]     stat_word;
    logic            unused_wdata;

    assign unused_wdata = ^writedata[31:3];
    assign running  = (state != ST_IDLE) && (state != ST_DONE);
    assign rise_en  = running && (div_cnt == DIV_LAST) && !sd_clk;
    assign ctrl_wr  = chipselect && !write_n && (address == ADDR_CTRL);
    assign start_ok = ctrl_wr && writedata[CTRL_START] && !running;
    assign pop      = chipselect && !read_n && (address == ADDR_DATA) && (level != '0);
    assign crc_en   = rise_en && (state == ST_DATA);
    assign irq      = done & irq_en;
    // First nibble of each byte is its high half; bytes fill the word from bit 0 up.
    assign nib_off  = {nib_idx[2:1], ~nib_idx[0], 2'b00};
    assign stat_word = {20'b0, fail_mask, 2'b0, irq_en, timeout, end_err, crc_err, done, running};

    for (genvar i = 0; i < 4; i++) begin : g_line
        nios2_c_sd_crc16_line u_crc (
            .clk   (clk),
            .reset (reset),
            .clr   (start_ok),
            .en    (crc_en),
            .din   (sd_dat_in[i]),
            .crc   (crc_line[i])
        );
        assign crc_miss[i] = crc_line[i][nib_cnt[3:0]] != sd_dat_in[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            sd_clk    <= 1'b0;
            tmo_cnt   <= '0;
            nib_cnt   <= '0;
            nib_idx   <= '0;
            word_buf  <= '0;
            push_pend <= 1'b0;
            done      <= 1'b0;
            crc_err   <= 1'b0;
            end_err   <= 1'b0;
            timeout   <= 1'b0;
            irq_en    <= 1'b0;
            fail_mask <= '0;
        end else begin
            push_pend <= 1'b0;

            if (!running || start_ok) begin
                div_cnt <= '0;
                sd_clk  <= 1'b0;
            end else if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                sd_clk  <= ~sd_clk;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (ctrl_wr) begin
                irq_en <= writedata[CTRL_IRQ_EN];
                if (writedata[CTRL_CLR]) begin
                    done      <= 1'b0;
                    crc_err   <= 1'b0;
                    end_err   <= 1'b0;
                    timeout   <= 1'b0;
                    fail_mask <= '0;
                end
            end

            if (start_ok) begin
                state     <= ST_WAIT_START;
                tmo_cnt   <= TMO_LAST;
                nib_idx   <= '0;
                done      <= 1'b0;
                crc_err   <= 1'b0;
                end_err   <= 1'b0;
                timeout   <= 1'b0;
                fail_mask <= '0;
            end else if (rise_en) begin
                case (state)
                    ST_WAIT_START: begin
                        if (sd_dat_in == 4'h0) begin
                            state   <= ST_DATA;
                            nib_cnt <= NIB_LAST;
                        end else if (tmo_cnt == '0) begin
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            tmo_cnt <= tmo_cnt - 1'b1;
                        end
                    end
                    ST_DATA: begin
                        word_buf[nib_off +: 4] <= sd_dat_in;
                        nib_idx <= nib_idx + 1'b1;
                        if (nib_idx == 3'd7) push_pend <= 1'b1;
                        if (nib_cnt == '0) begin
                            state   <= ST_CRC;
                            nib_cnt <= CRC_LAST;
                        end else begin
                            nib_cnt <= nib_cnt - 1'b1;
                        end
                    end
                    ST_CRC: begin
                        if (crc_miss != '0) begin
                            crc_err   <= 1'b1;
                            fail_mask <= fail_mask | crc_miss;
                        end
                        if (nib_cnt == '0) state <= ST_END;
                        else nib_cnt <= nib_cnt - 1'b1;
                    end
                    ST_END: begin
                        if (sd_dat_in != 4'hF) end_err <= 1'b1;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_pend) mem[wr_ptr] <= word_buf;
    end

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_pend) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
            if (pop)       rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            level <= level + LW'(push_pend) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else if (!chipselect) begin
            readdata <= '0;
        end else begin
            case (address)
                ADDR_CTRL:  readdata <= stat_word;
                ADDR_DATA:  readdata <= (level != '0) ? mem[rd_ptr] : 32'h0;
                ADDR_WORDS: readdata <= 32'(level);
                default:    readdata <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_c_sd_dat_rx.sv
// Bench for nios2_c_sd_dat_rx: card model driving DAT lines, register-map model of
// flags and FIFO contents, one per-cycle compare process.
module tb_nios2_c_sd_dat_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        irq;
    logic        sd_clk;
    logic [3:0]  sd_dat_in = 4'hF;

    nios2_c_sd_dat_rx #(.CLK_DIV(1), .BLOCK_BYTES(512), .TIMEOUT_CYC(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .sd_clk     (sd_clk),
        .sd_dat_in  (sd_dat_in)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // model of the programmer-visible state
    logic        m_busy = 0, m_done = 0, m_crc_err = 0, m_end_err = 0, m_timeout = 0, m_irq_en = 0;
    logic [3:0]  m_mask = 0;
    logic [31:0] m_q[$];

    logic        pend = 0;
    logic [31:0] pend_exp;
    string       pend_nm;
    logic [31:0] last_rd;
    logic        quiet_chk = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] m_stat();
        logic [31:0] s = 32'h0;
        s[0] = m_busy; s[1] = m_done; s[2] = m_crc_err; s[3] = m_end_err;
        s[4] = m_timeout; s[5] = m_irq_en; s[11:8] = m_mask;
        return s;
    endfunction

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return (b ^ c[15]) ? ((c << 1) ^ 16'h1021) : (c << 1);
    endfunction

    always @(negedge clk) begin
        if (pend) begin
            check(pend_nm, readdata, pend_exp);
            last_rd = readdata;
            pend = 0;
        end
        if (quiet_chk) begin
            check("irq_level", {31'b0, irq}, {31'b0, m_done & m_irq_en});
            if (!m_busy) check("sd_clk_idle", {31'b0, sd_clk}, 32'h0);
        end
    end

    task automatic bus_read(input logic [1:0] a, input string nm);
        logic [31:0] exp;
        case (a)
            2'd0: exp = m_stat();
            2'd1: exp = (m_q.size() != 0) ? m_q.pop_front() : 32'h0;
            2'd2: exp = 32'(m_q.size());
            default: exp = 32'h0;
        endcase
        @(posedge clk); #1;
        chipselect = 1; read_n = 0; address = a;
        @(posedge clk); #1;
        chipselect = 0; read_n = 1;
        pend_exp = exp; pend_nm = nm; pend = 1;
        @(negedge clk); #1;
    endtask

    task automatic bus_write(input logic [31:0] wd);
        @(posedge clk); #1;
        chipselect = 1; write_n = 0; address = 2'd0; writedata = wd;
        @(posedge clk); #1;
        chipselect = 0; write_n = 1;
        m_irq_en = wd[1];
        if (wd[2]) begin
            m_done = 0; m_crc_err = 0; m_end_err = 0; m_timeout = 0; m_mask = 0;
        end
        if (wd[0] && !m_busy) begin
            m_q.delete();
            m_done = 0; m_crc_err = 0; m_end_err = 0; m_timeout = 0; m_mask = 0;
            m_busy = 1;
        end
    endtask

    task automatic wait_fall(output bit ok);
        logic prev = sd_clk;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev && !sd_clk) begin
                ok = 1;
                return;
            end
            prev = sd_clk;
        end
        check("sd_clk_fall_timeout", 32'h0, 32'h1);
    endtask

    // Card side: idle, start nibble, bytes 0..255 twice, per-line CRC16, end nibble.
    task automatic send_block(input int flip_line, input int flip_bit, input logic [3:0] endv,
                              input int max_data);
        logic [3:0]  q[$];
        logic [15:0] crc[4];
        logic [7:0]  bval;
        logic [3:0]  n;
        int          total;
        bit          ok;
        q.push_back(4'hF); q.push_back(4'hF); q.push_back(4'h0);
        for (int l = 0; l < 4; l++) crc[l] = 16'h0;
        for (int b = 0; b < 512; b++) begin
            bval = 8'(b);
            for (int h = 0; h < 2; h++) begin
                n = (h == 0) ? bval[7:4] : bval[3:0];
                q.push_back(n);
                for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], n[l]);
            end
        end
        if (flip_line >= 0) crc[flip_line][flip_bit] = ~crc[flip_line][flip_bit];
        for (int k = 15; k >= 0; k--) q.push_back({crc[3][k], crc[2][k], crc[1][k], crc[0][k]});
        q.push_back(endv);
        total = (max_data < 0) ? q.size() : 3 + max_data;
        for (int i = 0; i < total; i++) begin
            wait_fall(ok);
            if (!ok) return;
            #1 sd_dat_in = q[i];
        end
        repeat (6) @(posedge clk);
        #1 sd_dat_in = 4'hF;
        if (max_data < 0) begin
            for (int w = 0; w < 128; w++)
                m_q.push_back({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
            m_busy = 0; m_done = 1;
            m_crc_err = (flip_line >= 0);
            m_mask = (flip_line >= 0) ? 4'(1 << flip_line) : 4'h0;
            m_end_err = (endv != 4'hF);
        end
    endtask

    task automatic drain(input int cnt);
        for (int i = 0; i < cnt; i++) bus_read(2'd1, "data_word");
    endtask

    initial begin
        int rises;
        logic prev;

        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        check("reset_sd_clk", {31'b0, sd_clk}, 32'h0);
        quiet_chk = 1;
        bus_read(2'd0, "reset_stat");
        bus_read(2'd2, "reset_words");
        bus_read(2'd1, "empty_data_read");
        check("empty_read_lit", last_rd, 32'h0);
        bus_read(2'd2, "empty_level_stays");

        // good block
        quiet_chk = 0;
        bus_write(32'h1);
        send_block(-1, 0, 4'hF, -1);
        quiet_chk = 1;
        bus_read(2'd0, "good_stat");
        check("good_stat_lit", last_rd, 32'h0000_0002);
        bus_read(2'd2, "good_words");
        check("good_words_lit", last_rd, 32'd128);
        bus_read(2'd1, "good_first");
        check("good_first_lit", last_rd, 32'h0302_0100);
        drain(126);
        bus_read(2'd1, "good_last");
        check("good_last_lit", last_rd, 32'hFFFE_FDFC);
        bus_read(2'd2, "good_words_after");

        // line 2 CRC bit 5 corrupted
        quiet_chk = 0;
        bus_write(32'h1);
        send_block(2, 5, 4'hF, -1);
        quiet_chk = 1;
        bus_read(2'd0, "crc_stat");
        check("crc_stat_lit", last_rd, 32'h0000_0406);
        bus_read(2'd2, "crc_words");
        drain(3);

        // bad end bit with interrupt enabled
        quiet_chk = 0;
        bus_write(32'h3);
        send_block(-1, 0, 4'hE, -1);
        quiet_chk = 1;
        bus_read(2'd0, "end_stat");
        check("end_stat_lit", last_rd, 32'h0000_002A);
        check("irq_set_lit", {31'b0, irq}, 32'h1);
        bus_write(32'h6);
        @(negedge clk);
        check("irq_clr_lit", {31'b0, irq}, 32'h0);
        bus_read(2'd0, "clr_stat");
        bus_read(2'd2, "clr_words");

        // no start bit -> timeout after 16 rises
        quiet_chk = 0;
        bus_write(32'h1);
        rises = 0;
        prev = sd_clk;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!prev && sd_clk) rises++;
            prev = sd_clk;
        end
        check("timeout_rises", 32'(rises), 32'd16);
        m_busy = 0; m_done = 1; m_timeout = 1;
        quiet_chk = 1;
        bus_read(2'd0, "timeout_stat");
        check("timeout_stat_lit", last_rd, 32'h0000_0012);
        bus_read(2'd2, "timeout_words");

        // START while busy is ignored
        quiet_chk = 0;
        bus_write(32'h1);
        fork
            send_block(-1, 0, 4'hF, -1);
            begin
                repeat (300) @(posedge clk);
                bus_write(32'h1);
            end
        join
        quiet_chk = 1;
        bus_read(2'd0, "busy_start_stat");
        bus_read(2'd2, "busy_start_words");
        drain(4);
        bus_read(2'd2, "after_pop_words");
        check("after_pop_words_lit", last_rd, 32'd124);

        // reset in the middle of DATA
        quiet_chk = 0;
        bus_write(32'h1);
        send_block(-1, 0, 4'hF, 300);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        sd_dat_in = 4'hF;
        m_q.delete();
        m_busy = 0; m_done = 0; m_crc_err = 0; m_end_err = 0; m_timeout = 0; m_irq_en = 0; m_mask = 0;
        @(negedge clk);
        check("midreset_sd_clk", {31'b0, sd_clk}, 32'h0);
        quiet_chk = 1;
        bus_read(2'd0, "midreset_stat");
        bus_read(2'd2, "midreset_words");

        // fresh block after reset
        quiet_chk = 0;
        bus_write(32'h1);
        send_block(-1, 0, 4'hF, -1);
        quiet_chk = 1;
        bus_read(2'd0, "fresh_stat");
        bus_read(2'd2, "fresh_words");
        bus_read(2'd1, "fresh_first");
        check("fresh_first_lit", last_rd, 32'h0302_0100);
        drain(127);
        bus_read(2'd2, "fresh_words_after");

        quiet_chk = 0;
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
